// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage RV32I pipeline registers.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   // ResultSrc encodings
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   // Control bundle carried from Decode into Execute
   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Branch;
      logic       Jump;
      logic [2:0] ALUControl;
      logic       ALUSrc;
   } ctrl_e_t;

   localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in Execute whose destination is read by Decode.
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic       ValidE,
   input  logic [1:0] ResultSrcE,
   input  logic [4:0] RdE,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   output logic       lwStall
);

   // Purely E-side state plus Decode sources; no redirect input by construction
   always_comb begin
      lwStall = ValidE & (ResultSrcE == RESULT_MEM) & (RdE != 5'd0) &
                ((Rs1D == RdE) | (Rs2D == RdE));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect flush and bubble counter.
module id_ex_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN  = pipeline_pkg::XLEN,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ValidD,
   input  logic             RegWriteD,
   input  logic             ALUSrcD,
   input  logic             MemWriteD,
   input  logic             BranchD,
   input  logic             JumpD,
   input  logic [1:0]       ResultSrcD,
   input  logic [2:0]       ALUControlD,
   input  logic [XLEN-1:0]  RD1D,
   input  logic [XLEN-1:0]  RD2D,
   input  logic [XLEN-1:0]  ImmExtD,
   input  logic [XLEN-1:0]  PCD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             PCSrcE,
   output logic             ValidE,
   output logic             RegWriteE,
   output logic             ALUSrcE,
   output logic             MemWriteE,
   output logic             BranchE,
   output logic             JumpE,
   output logic [1:0]       ResultSrcE,
   output logic [2:0]       ALUControlE,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [4:0]       RdE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic [CNT_W-1:0] BubbleCnt
);

   ctrl_e_t          ctrl_d, ctrl_q;
   logic             valid_d, valid_q;
   logic [XLEN-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
   logic [XLEN-1:0]  pc_d, pc_q, pc4_d, pc4_q;
   logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             lw_stall;
   logic             flush_e;

   load_use_detect u_load_use_detect (
      .ValidE     (valid_q),
      .ResultSrcE (ctrl_q.ResultSrc),
      .RdE        (rd_q),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .lwStall    (lw_stall)
   );

   assign flush_e = lw_stall | PCSrcE;
   assign StallF  = lw_stall;
   assign StallD  = lw_stall;
   assign FlushD  = PCSrcE;

   // Flush mux: a bubble is all zeros; an illegal Decode slot is also a bubble
   always_comb begin
      ctrl_d  = CTRL_BUBBLE;
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      pc4_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      if (!flush_e && ValidD) begin
         ctrl_d.RegWrite   = RegWriteD;
         ctrl_d.ResultSrc  = ResultSrcD;
         ctrl_d.MemWrite   = MemWriteD;
         ctrl_d.Branch     = BranchD;
         ctrl_d.Jump       = JumpD;
         ctrl_d.ALUControl = ALUControlD;
         ctrl_d.ALUSrc     = ALUSrcD;
         valid_d = 1'b1;
         rd1_d   = RD1D;
         rd2_d   = RD2D;
         imm_d   = ImmExtD;
         pc_d    = PCD;
         pc4_d   = PCPlus4D;
         rs1_d   = Rs1D;
         rs2_d   = Rs2D;
         rd_d    = RdD;
      end
   end

   // Saturating count of inserted bubbles; invalid Decode slots are not counted
   always_comb begin
      cnt_d = cnt_q;
      if (flush_e && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Pipeline register and counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_BUBBLE;
         valid_q <= 1'b0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         pc4_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ValidE      = valid_q;
   assign RegWriteE   = ctrl_q.RegWrite;
   assign ResultSrcE  = ctrl_q.ResultSrc;
   assign MemWriteE   = ctrl_q.MemWrite;
   assign BranchE     = ctrl_q.Branch;
   assign JumpE       = ctrl_q.Jump;
   assign ALUControlE = ctrl_q.ALUControl;
   assign ALUSrcE     = ctrl_q.ALUSrc;
   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign ImmExtE     = imm_q;
   assign PCE         = pc_q;
   assign PCPlus4E    = pc4_q;
   assign Rs1E        = rs1_q;
   assign Rs2E        = rs2_q;
   assign RdE         = rd_q;
   assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for the ID/EX stage.
module tb_id_ex_stage;

   logic        clk, rst_n;
   logic        ValidD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD;
   logic [1:0]  ResultSrcD;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        PCSrcE;
   logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        StallF, StallD, FlushD;
   logic [15:0] BubbleCnt;

   int n_checks = 0;
   int n_err    = 0;

   id_ex_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ValidD      (ValidD),
      .RegWriteD   (RegWriteD),
      .ALUSrcD     (ALUSrcD),
      .MemWriteD   (MemWriteD),
      .BranchD     (BranchD),
      .JumpD       (JumpD),
      .ResultSrcD  (ResultSrcD),
      .ALUControlD (ALUControlD),
      .RD1D        (RD1D),
      .RD2D        (RD2D),
      .ImmExtD     (ImmExtD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .RdD         (RdD),
      .PCSrcE      (PCSrcE),
      .ValidE      (ValidE),
      .RegWriteE   (RegWriteE),
      .ALUSrcE     (ALUSrcE),
      .MemWriteE   (MemWriteE),
      .BranchE     (BranchE),
      .JumpE       (JumpE),
      .ResultSrcE  (ResultSrcE),
      .ALUControlE (ALUControlE),
      .RD1E        (RD1E),
      .RD2E        (RD2E),
      .ImmExtE     (ImmExtE),
      .PCE         (PCE),
      .PCPlus4E    (PCPlus4E),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .BubbleCnt   (BubbleCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        rw;
      logic [1:0]  rsrc;
      logic        mw;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic        pcsrc;
      logic        e_stall;
      logic        e_flushd;
      logic        e_valid;
      logic        e_mw;
      logic [4:0]  e_rd;
      logic [31:0] e_rd1;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vec [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Other D fields are derived from RD1D so every row has distinct values
   task automatic drive(input vec_t v);
      ValidD      = v.valid;
      RegWriteD   = v.rw;
      ResultSrcD  = v.rsrc;
      MemWriteD   = v.mw;
      Rs1D        = v.rs1;
      Rs2D        = v.rs2;
      RdD         = v.rd;
      RD1D        = v.rd1;
      RD2D        = v.rd1 + 32'd1;
      ImmExtD     = v.rd1 + 32'd2;
      PCD         = v.rd1 << 4;
      PCPlus4D    = (v.rd1 << 4) + 32'd4;
      ALUControlD = v.rd1[2:0];
      ALUSrcD     = v.rd1[0];
      BranchD     = v.rd1[1];
      JumpD       = v.rd1[3];
      PCSrcE      = v.pcsrc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, {63'd0, ValidE}, 64'd0);
      check({tag, "_ctrl"}, {53'd0, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
                             ALUControlE, ALUSrcE}, 64'd0);
      check({tag, "_rd12"}, {RD1E, RD2E}, 64'd0);
      check({tag, "_imm_pc"}, {ImmExtE, PCE}, 64'd0);
      check({tag, "_pc4"}, {32'd0, PCPlus4E}, 64'd0);
      check({tag, "_idx"}, {49'd0, Rs1E, Rs2E, RdE}, 64'd0);
      check({tag, "_cnt"}, {48'd0, BubbleCnt}, 64'd0);
   endtask

   initial begin
      vec_t v;
      // valid rw rsrc mw rs1 rs2 rd rd1 | pcsrc | stall flushd | e_valid e_mw e_rd e_rd1 e_cnt
      vec[0]  = '{1, 1, 2'b00, 0, 6, 7, 5, 32'h11, 0, 0, 0, 1, 0, 5, 32'h11, 0};   // add x5
      vec[1]  = '{1, 1, 2'b01, 0, 9, 0, 8, 32'h100, 0, 0, 0, 1, 0, 8, 32'h100, 0}; // lw x8
      vec[2]  = '{1, 0, 2'b00, 1, 2, 8, 0, 32'h33, 0, 1, 0, 0, 0, 0, 32'h0, 1};    // sw x8: stall
      vec[3]  = '{1, 0, 2'b00, 1, 2, 8, 0, 32'h33, 0, 0, 0, 1, 1, 0, 32'h33, 1};   // sw retried
      vec[4]  = '{1, 1, 2'b01, 0, 0, 0, 0, 32'h44, 0, 0, 0, 1, 0, 0, 32'h44, 1};   // lw x0
      vec[5]  = '{1, 1, 2'b00, 0, 0, 0, 3, 32'h55, 0, 0, 0, 1, 0, 3, 32'h55, 1};   // x0 immune
      vec[6]  = '{1, 0, 2'b00, 1, 1, 2, 0, 32'h66, 1, 0, 1, 0, 0, 0, 32'h0, 2};    // redirect sw
      vec[7]  = '{0, 1, 2'b00, 0, 1, 2, 7, 32'h77, 0, 0, 0, 0, 0, 0, 32'h0, 2};    // illegal D
      vec[8]  = '{1, 1, 2'b01, 0, 1, 1, 4, 32'h88, 0, 0, 0, 1, 0, 4, 32'h88, 2};   // lw x4
      vec[9]  = '{1, 1, 2'b00, 0, 4, 0, 6, 32'h99, 1, 1, 1, 0, 0, 0, 32'h0, 3};    // stall+redirect
      vec[10] = '{1, 1, 2'b00, 0, 4, 0, 6, 32'h99, 0, 0, 0, 1, 0, 6, 32'h99, 3};   // retried

      // Reset, then build nonzero state including a pending load-use stall
      v = vec[0];
      drive(v);
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      check_all_zero("reset_init");
      PCSrcE = 1'b1;
      step();
      check("pre_rst_cnt", {48'd0, BubbleCnt}, 64'd1);
      v = '{1, 1, 2'b01, 0, 5, 5, 5, 32'hABC, 0, 0, 0, 0, 0, 0, 32'h0, 0};
      drive(v);
      step();
      check("pre_rst_valid", {63'd0, ValidE}, 64'd1);
      check("pre_rst_stall", {62'd0, StallF, StallD}, 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_async");
      check("reset_stall", {61'd0, StallF, StallD, FlushD}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_stall", {61'd0, StallF, StallD, FlushD}, 64'd0);

      // Table-driven sequence
      for (int i = 0; i < 11; i++) begin
         logic [63:0] exp_ctrl;
         v = vec[i];
         drive(v);
         #1;
         check($sformatf("v%0d_stallf", i), {63'd0, StallF}, {63'd0, v.e_stall});
         check($sformatf("v%0d_stalld", i), {63'd0, StallD}, {63'd0, v.e_stall});
         check($sformatf("v%0d_flushd", i), {63'd0, FlushD}, {63'd0, v.e_flushd});
         step();
         check($sformatf("v%0d_validE", i), {63'd0, ValidE}, {63'd0, v.e_valid});
         check($sformatf("v%0d_memwE", i), {63'd0, MemWriteE}, {63'd0, v.e_mw});
         check($sformatf("v%0d_rdE", i), {59'd0, RdE}, {59'd0, v.e_rd});
         check($sformatf("v%0d_rd1E", i), {32'd0, RD1E}, {32'd0, v.e_rd1});
         check($sformatf("v%0d_cnt", i), {48'd0, BubbleCnt}, {48'd0, v.e_cnt});
         if (v.e_valid) begin
            exp_ctrl = {53'd0, v.rw, v.rsrc, v.mw, v.rd1[1], v.rd1[3], v.rd1[2:0], v.rd1[0]};
            check($sformatf("v%0d_rd2_imm", i), {RD2E, ImmExtE},
                  {v.rd1 + 32'd1, v.rd1 + 32'd2});
            check($sformatf("v%0d_pc", i), {PCE, PCPlus4E},
                  {v.rd1 << 4, (v.rd1 << 4) + 32'd4});
            check($sformatf("v%0d_rs", i), {54'd0, Rs1E, Rs2E}, {54'd0, v.rs1, v.rs2});
         end else begin
            exp_ctrl = 64'd0;
            check($sformatf("v%0d_bub_data", i), {RD2E, ImmExtE}, 64'd0);
            check($sformatf("v%0d_bub_idx", i), {54'd0, Rs1E, Rs2E}, 64'd0);
         end
         check($sformatf("v%0d_ctrl", i), {53'd0, RegWriteE, ResultSrcE, MemWriteE, BranchE,
                                           JumpE, ALUControlE, ALUSrcE}, exp_ctrl);
      end

      // Saturation: drive redirects until the counter reaches all-ones
      ValidD = 1'b0;
      PCSrcE = 1'b1;
      for (int i = 0; i < 65535 - 3; i++) begin
         step();
      end
      check("sat_reach", {48'd0, BubbleCnt}, 64'hFFFF);
      step();
      check("sat_hold1", {48'd0, BubbleCnt}, 64'hFFFF);
      step();
      check("sat_hold2", {48'd0, BubbleCnt}, 64'hFFFF);
      PCSrcE = 1'b0;
      step();
      check("sat_idle", {48'd0, BubbleCnt}, 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
